// File: rtl/avg_pkg.sv
// Shared opcode, state and decode helpers for the AVG vector fetch/sequencing engine.
package avg_pkg;

  localparam logic [2:0] OP_VCTR   = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_SVEC   = 3'd2;
  localparam logic [2:0] OP_STAT   = 3'd3;
  localparam logic [2:0] OP_CENTER = 3'd4;
  localparam logic [2:0] OP_JSR    = 3'd5;
  localparam logic [2:0] OP_RTS    = 3'd6;
  localparam logic [2:0] OP_JMP    = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    L0,
    L1,
    W1,
    L2,
    L3,
    W3,
    EX,
    ERR
  } avg_state_e;

  // Instruction length in bytes; only VCTR carries the extra two bytes.
  function automatic logic [2:0] instr_len(input logic [2:0] opc);
    return (opc == OP_VCTR) ? 3'd4 : 3'd2;
  endfunction

  // Opcodes that are handed to the vector datapath rather than resolved here.
  function automatic logic is_draw(input logic [2:0] opc);
    return (opc == OP_VCTR) || (opc == OP_SVEC) ||
           (opc == OP_STAT) || (opc == OP_CENTER);
  endfunction

endpackage

// File: rtl/avg_ret_stack.sv
// Return-address LIFO for JSR/RTS; occupancy is exported so the sequencer can flag faults.
module avg_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 14,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          state_clk_not,
  input  logic          DISRST_not,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [0:(1 << AW) - 1];
  logic [CW-1:0] count_q;
  logic [CW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign top_idx = count_q - CW'(1);
  assign dout    = empty ? '0 : mem_q[top_idx[AW-1:0]];

  always_ff @(posedge state_clk_not or negedge DISRST_not) begin
    if (!DISRST_not) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CW'(1);
    end else if (do_pop) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Entry contents need no reset: occupancy alone defines what is valid.
  always_ff @(posedge state_clk_not) begin
    if (do_push) begin
      mem_q[count_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/avg_fetch_seq.sv
// AVG instruction fetch/sequencing engine: byte fetch, instruction assembly,
// internal flow control via a return stack, and valid/ready hand-off of drawing ops.
module avg_fetch_seq
  import avg_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 14,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
  input  logic                               state_clk_not,
  input  logic                               DISRST_not,
  input  logic                               vggo,
  input  logic                               abort,
  output logic                               mem_rd,
  output logic [ADDR_W-1:0]                  mem_addr,
  input  logic [7:0]                         mem_data,
  output logic [3:0]                         latch_stb,
  output logic [31:0]                        instr,
  output logic [2:0]                         op,
  output logic                               instr_valid,
  input  logic                               instr_ready,
  output logic                               busy,
  output logic                               halted,
  output logic                               err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  avg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;

  logic              stk_push, stk_pop, stk_clr;
  logic              stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_dout;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] target;
  logic [13:0]       tgt_byte;
  logic [2:0]        op_w;

  assign op_w     = instr_q[15:13];
  assign tgt_byte = {instr_q[12:8], instr_q[7:0], 1'b0};
  assign target   = ADDR_W'(tgt_byte);
  assign ret_addr = pc_q + ADDR_W'(2);

  avg_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .state_clk_not (state_clk_not),
    .DISRST_not    (DISRST_not),
    .clr           (stk_clr),
    .push          (stk_push),
    .pop           (stk_pop),
    .din           (ret_addr),
    .dout          (stk_dout),
    .full          (stk_full),
    .empty         (stk_empty),
    .count         (sp)
  );

  always_ff @(posedge state_clk_not or negedge DISRST_not) begin
    if (!DISRST_not) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (vggo) begin
      state_d = L0;
      pc_d    = START_ADDR;
      err_d   = 1'b0;
      stk_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        L0:   state_d = L1;
        L1: begin
          // Clearing upper bytes here keeps b2/b3 zero for 2-byte instructions.
          instr_d = {24'h0, mem_data};
          state_d = W1;
        end
        W1: begin
          instr_d[15:8] = mem_data;
          state_d       = (mem_data[7:5] == OP_VCTR) ? L2 : EX;
        end
        L2: state_d = L3;
        L3: begin
          instr_d[23:16] = mem_data;
          state_d        = W3;
        end
        W3: begin
          instr_d[31:24] = mem_data;
          state_d        = EX;
        end
        EX: begin
          unique case (op_w)
            OP_HALT: state_d = IDLE;
            OP_JMP: begin
              pc_d    = target;
              state_d = L0;
            end
            OP_JSR: begin
              if (stk_full) begin
                err_d   = 1'b1;
                state_d = ERR;
              end else begin
                stk_push = 1'b1;
                pc_d     = target;
                state_d  = L0;
              end
            end
            OP_RTS: begin
              if (stk_empty) begin
                err_d   = 1'b1;
                state_d = ERR;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_dout;
                state_d = L0;
              end
            end
            default: begin
              if (instr_ready) begin
                pc_d    = pc_q + ADDR_W'(instr_len(op_w));
                state_d = L0;
              end
            end
          endcase
        end
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd      = 1'b0;
    mem_addr    = '0;
    latch_stb   = 4'b0000;
    instr_valid = 1'b0;
    busy        = (state_q != IDLE) && (state_q != ERR);
    halted      = (state_q == IDLE) || (state_q == ERR);
    unique case (state_q)
      L0: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
      end
      L1: begin
        mem_rd       = 1'b1;
        mem_addr     = pc_q + ADDR_W'(1);
        latch_stb[0] = 1'b1;
      end
      W1: latch_stb[1] = 1'b1;
      L2: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(2);
      end
      L3: begin
        mem_rd       = 1'b1;
        mem_addr     = pc_q + ADDR_W'(3);
        latch_stb[2] = 1'b1;
      end
      W3: latch_stb[3] = 1'b1;
      EX: instr_valid = is_draw(op_w);
      default: ;
    endcase
  end

  assign instr = instr_q;
  assign op    = op_w;
  assign err   = err_q;

endmodule
